// File: rtl/alu_if.sv
// Operand/result bundle for the registered ALU: opcode and operands in, result and flags out.
interface alu_if;
   logic [2:0]  alu_op;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] alu_out;
   logic        zero;
   logic        ovf;

   modport master (output alu_op, a, b, input alu_out, zero, ovf);
   modport slave  (input alu_op, a, b, output alu_out, zero, ovf);
endinterface

// File: rtl/alu.sv
// 32-bit registered ALU (ADD/SUB/AND/OR/XOR/SLT), one-cycle latency, zero and signed-overflow flags.
// Optional shifts (110 SLL, 111 SRL) are built only when ALU_SHIFT_EN is defined.
module alu_core (
   input  logic  clk_i,
   input  logic  reset_i,
   alu_if.slave  bus
);
   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SLT = 3'b101;
`ifdef ALU_SHIFT_EN
   localparam logic [2:0] OP_SLL = 3'b110;
   localparam logic [2:0] OP_SRL = 3'b111;
`endif

   logic [31:0] sum;
   logic [31:0] diff;
   logic [31:0] alu_out_d, alu_out_q;
   logic        ovf_d, ovf_q;
   logic        zero_q;

   assign sum  = bus.a + bus.b;
   assign diff = bus.a - bus.b;

   always_comb begin
      alu_out_d = 32'h0;
      ovf_d     = 1'b0;
      case (bus.alu_op)
         OP_ADD: begin
            alu_out_d = sum;
            ovf_d     = (bus.a[31] == bus.b[31]) && (sum[31] != bus.a[31]);
         end
         OP_SUB: begin
            alu_out_d = diff;
            ovf_d     = (bus.a[31] != bus.b[31]) && (diff[31] != bus.a[31]);
         end
         OP_AND: alu_out_d = bus.a & bus.b;
         OP_OR:  alu_out_d = bus.a | bus.b;
         OP_XOR: alu_out_d = bus.a ^ bus.b;
         OP_SLT: alu_out_d = {31'h0, $signed(bus.a) < $signed(bus.b)};
`ifdef ALU_SHIFT_EN
         OP_SLL: alu_out_d = bus.a << bus.b[4:0];
         OP_SRL: alu_out_d = bus.a >> bus.b[4:0];
`endif
         default: begin
            alu_out_d = 32'h0;
            ovf_d     = 1'b0;
         end
      endcase
   end

   // Zero is derived from the same next-state value so it can never disagree with ALUOut.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         alu_out_q <= 32'h0;
         zero_q    <= 1'b1;
         ovf_q     <= 1'b0;
      end else begin
         alu_out_q <= alu_out_d;
         zero_q    <= (alu_out_d == 32'h0);
         ovf_q     <= ovf_d;
      end
   end

   assign bus.alu_out = alu_out_q;
   assign bus.zero    = zero_q;
   assign bus.ovf     = ovf_q;
endmodule

// Legacy-compatible port list (reset last) so positional instantiations keep working.
module alu (
   input  logic        clk,
   input  logic [2:0]  ALU_OP,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic [31:0] ALUOut,
   output logic        Zero,
   output logic        OF,
   input  logic        reset
);
   alu_if u_bus ();

   assign u_bus.alu_op = ALU_OP;
   assign u_bus.a      = A;
   assign u_bus.b      = B;
   assign ALUOut       = u_bus.alu_out;
   assign Zero         = u_bus.zero;
   assign OF           = u_bus.ovf;

   alu_core u_core (
      .clk_i   (clk),
      .reset_i (reset),
      .bus     (u_bus.slave)
   );
endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases plus randomized stimulus against an arithmetic reference model.
module tb_alu;
   logic clk;
   logic reset;
   int   n_chk;
   int   n_err;

   alu_if bus ();

   alu u_dut (
      .clk    (clk),
      .ALU_OP (bus.alu_op),
      .A      (bus.a),
      .B      (bus.b),
      .ALUOut (bus.alu_out),
      .Zero   (bus.zero),
      .OF     (bus.ovf),
      .reset  (reset)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   // Reference from the arithmetic rules: 64-bit signed math for overflow/SLT, mul/div for shifts.
   function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic o);
      longint sa, sb, s;
      longint maxp, minn;
      logic [31:0] pw;
      sa   = longint'($signed(a));
      sb   = longint'($signed(b));
      maxp = 64'sd2147483647;
      minn = -maxp - 64'sd1;
      pw   = 32'd1 << b[4:0];
      r    = 32'h0;
      o    = 1'b0;
      case (op)
         3'd0: begin s = sa + sb; r = s[31:0]; o = (s > maxp) || (s < minn); end
         3'd1: begin s = sa - sb; r = s[31:0]; o = (s > maxp) || (s < minn); end
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: r = a ^ b;
         3'd5: r = (sa < sb) ? 32'd1 : 32'd0;
`ifdef ALU_SHIFT_EN
         3'd6: r = a * pw;
         3'd7: r = a / pw;
`endif
         default: r = 32'h0;
      endcase
   endfunction

   task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.alu_op = op;
      bus.a      = a;
      bus.b      = b;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic [31:0] r, input logic z, input logic o);
      chk({tag, ".out"},  bus.alu_out, r);
      chk({tag, ".zero"}, {31'h0, bus.zero}, {31'h0, z});
      chk({tag, ".of"},   {31'h0, bus.ovf}, {31'h0, o});
   endtask

   logic [31:0] sweep_exp [6];
   logic [31:0] corners [8];

   initial begin
      logic [31:0] r, a, b;
      logic        o;
      logic [2:0]  op;
      n_chk = 0;
      n_err = 0;
      sweep_exp = '{32'hFEFF5900, 32'hFF010700, 32'hFF002000, 32'hFFFF3900, 32'h00FF1900, 32'h00000001};
      corners   = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h80000001, 32'h7FFFFFFE, 32'h1F};

      // Reset held two edges, then first operation
      reset = 1'b1;
      drive(3'd0, 32'hDEADBEEF, 32'h12345678);
      tick();
      tick();
      expect_out("reset", 32'h0, 1'b1, 1'b0);
      reset = 1'b0;
      drive(3'd0, 32'd5, 32'd3);
      tick();
      expect_out("first_add", 32'd8, 1'b0, 1'b0);

      // Opcode sweep on fixed operands
      for (int k = 0; k < 6; k++) begin
         drive(3'(k), 32'hFF003000, 32'hFFFF2900);
         tick();
         expect_out($sformatf("sweep%0d", k), sweep_exp[k], 1'b0, 1'b0);
      end

      // Inputs changing between edges must not disturb registered outputs
      drive(3'd2, 32'h0, 32'h0);
      #3;
      expect_out("hold", 32'h00000001, 1'b0, 1'b0);

      drive(3'd0, 32'h7FFFFFFF, 32'h1);
      tick();
      expect_out("add_ovf", 32'h80000000, 1'b0, 1'b1);
      drive(3'd1, 32'h80000000, 32'h1);
      tick();
      expect_out("sub_ovf", 32'h7FFFFFFF, 1'b0, 1'b1);
      drive(3'd0, 32'hFFFFFFFF, 32'h1);
      tick();
      expect_out("add_wrap", 32'h0, 1'b1, 1'b0);
      drive(3'd1, 32'h1234ABCD, 32'h1234ABCD);
      tick();
      expect_out("sub_eq", 32'h0, 1'b1, 1'b0);
      drive(3'd5, 32'h1, 32'hFFFFFFFF);
      tick();
      expect_out("slt_neg", 32'h0, 1'b1, 1'b0);

      // Reset priority over an overflowing add, then recovery
      reset = 1'b1;
      drive(3'd0, 32'h7FFFFFFF, 32'h1);
      tick();
      expect_out("rst_prio", 32'h0, 1'b1, 1'b0);
      reset = 1'b0;
      tick();
      expect_out("rst_after", 32'h80000000, 1'b0, 1'b1);

      // Shift opcodes (or their disabled behaviour)
`ifdef ALU_SHIFT_EN
      drive(3'd6, 32'h00000001, 32'h0000001F);
      tick();
      expect_out("sll31", 32'h80000000, 1'b0, 1'b0);
      drive(3'd7, 32'h80000000, 32'h0000001F);
      tick();
      expect_out("srl31", 32'h00000001, 1'b0, 1'b0);
      drive(3'd6, 32'hA5A50F0F, 32'hFFFFFFE0);
      tick();
      expect_out("sll0", 32'hA5A50F0F, 1'b0, 1'b0);
`else
      drive(3'd6, 32'h00000001, 32'h0000001F);
      tick();
      expect_out("op6_off", 32'h0, 1'b1, 1'b0);
      drive(3'd7, 32'h80000000, 32'h0000001F);
      tick();
      expect_out("op7_off", 32'h0, 1'b1, 1'b0);
`endif

      // Randomized stream with corner-biased operands and sporadic reset
      for (int i = 0; i < 400; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 7)] : 32'($urandom);
         b  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 7)] : 32'($urandom);
         if ($urandom_range(0, 7) == 0) b = a;
         reset = ($urandom_range(0, 15) == 0);
         drive(op, a, b);
         model(op, a, b, r, o);
         if (reset) begin
            r = 32'h0;
            o = 1'b0;
         end
         tick();
         expect_out($sformatf("rnd%0d_op%0d", i, op), r, (r == 32'h0), o);
      end
      reset = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
